// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths and enums for the unified memory arbiter
package mem_arbiter_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RESP} arb_state_t;
  typedef enum logic {OWNER_IF, OWNER_D} arb_owner_t;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin pick favouring the port not granted last
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic       if_valid,
  input  logic       d_valid,
  input  arb_owner_t last_grant,
  output arb_owner_t grant,
  output logic       grant_valid
);
  // on a tie the port that did not win last time goes next
  always_comb begin
    grant_valid = if_valid || d_valid;
    grant = (if_valid && d_valid) ? ((last_grant == OWNER_IF) ? OWNER_D : OWNER_IF)
          : (d_valid ? OWNER_D : OWNER_IF);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data, one transaction in flight
module mem_arbiter #(
  parameter int DATA_WIDTH = mem_arbiter_pkg::DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req_valid,
  output logic                    if_req_ready,
  input  logic [DATA_WIDTH-1:0]   if_addr,
  output logic                    if_resp_valid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    d_req_valid,
  output logic                    d_req_ready,
  input  logic [DATA_WIDTH-1:0]   d_addr,
  input  logic                    d_we,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_resp_valid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [DATA_WIDTH-1:0]   mem_addr,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy
);
  import mem_arbiter_pkg::*;
  arb_state_t state;
  arb_owner_t owner, last_grant, grant;
  logic       grant_valid, accept, resp;
  rr_pick2 u_pick (
    .if_valid   (if_req_valid),
    .d_valid    (d_req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_valid(grant_valid)
  );
  // readiness and response routing are combinational so a grant and a response land in their own cycle
  always_comb begin
    accept        = rst_n && (state == ARB_IDLE) && grant_valid;
    if_req_ready  = accept && (grant == OWNER_IF);
    d_req_ready   = accept && (grant == OWNER_D);
    resp          = (state == ARB_RESP) && mem_resp_valid;
    if_resp_valid = resp && (owner == OWNER_IF);
    d_resp_valid  = resp && (owner == OWNER_D);
    if_rdata      = if_resp_valid ? mem_rdata : '0;
    d_rdata       = d_resp_valid ? mem_rdata : '0;
    mem_req_valid = (state == ARB_REQ);
    busy          = (state != ARB_IDLE);
  end
  // arbitration FSM with capture of the granted request; fetches are word aligned and never write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      owner      <= OWNER_IF;
      last_grant <= OWNER_D;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wstrb  <= '0;
      mem_wdata  <= '0;
    end else if (accept) begin
      state      <= ARB_REQ;
      owner      <= grant;
      last_grant <= grant;
      mem_addr   <= (grant == OWNER_D) ? d_addr : (if_addr & ~DATA_WIDTH'(3));
      mem_we     <= (grant == OWNER_D) && d_we;
      mem_wstrb  <= ((grant == OWNER_D) && d_we) ? d_wstrb : '0;
      mem_wdata  <= (grant == OWNER_D) ? d_wdata : '0;
    end else if (state == ARB_REQ && mem_req_ready) begin
      state <= ARB_RESP;
    end else if (resp) begin
      state <= ARB_IDLE;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_mem_arbiter;
  logic        clk = 0, rst_n = 0;
  logic        if_req_valid = 0, if_req_ready, if_resp_valid;
  logic [31:0] if_addr = 0, if_rdata;
  logic        d_req_valid = 0, d_req_ready, d_we = 0, d_resp_valid;
  logic [31:0] d_addr = 0, d_wdata = 0, d_rdata;
  logic [3:0]  d_wstrb = 0;
  logic        mem_req_valid, mem_req_ready = 0, mem_we, mem_resp_valid = 0, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0]  mem_wstrb;
  int total = 0, bad = 0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr), .d_we(d_we),
    .d_wstrb(d_wstrb), .d_wdata(d_wdata), .d_resp_valid(d_resp_valid), .d_rdata(d_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    if_req_valid = 0; d_req_valid = 0; d_we = 0; d_wstrb = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0; if_req_valid = 1; d_req_valid = 1; mem_resp_valid = 1; mem_rdata = 32'h55AA_55AA;
    #1;
    total++; if (if_req_ready !== 1'b0) begin bad++; $display("FAIL reset_if_ready got=%b want=0", if_req_ready); end
    total++; if (d_req_ready !== 1'b0) begin bad++; $display("FAIL reset_d_ready got=%b want=0", d_req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_req_valid got=%b want=0", mem_req_valid); end
    total++; if ({mem_addr, mem_wdata, mem_wstrb, mem_we} !== 69'd0) begin bad++; $display("FAIL reset_mem_fields got=%h/%h/%h/%b want=0", mem_addr, mem_wdata, mem_wstrb, mem_we); end
    total++; if ({if_resp_valid, d_resp_valid} !== 2'b00) begin bad++; $display("FAIL reset_resp_valid got=%b%b want=00", if_resp_valid, d_resp_valid); end
    total++; if ({if_rdata, d_rdata} !== 64'd0) begin bad++; $display("FAIL reset_rdata got=%h/%h want=0", if_rdata, d_rdata); end
    do_reset();
  endtask

  task automatic test_fetch_only();
    @(negedge clk);
    if_req_valid = 1; if_addr = 32'h0000_0006;
    #1;
    total++; if ({if_req_ready, d_req_ready} !== 2'b10) begin bad++; $display("FAIL fetch_ready got=%b%b want=10", if_req_ready, d_req_ready); end
    @(negedge clk);
    if_req_valid = 0; mem_req_ready = 1;
    #1;
    total++; if (mem_req_valid !== 1'b1) begin bad++; $display("FAIL fetch_mem_req_valid got=%b want=1", mem_req_valid); end
    total++; if (mem_addr !== 32'h0000_0004) begin bad++; $display("FAIL fetch_mem_addr got=%h want=00000004", mem_addr); end
    total++; if ({mem_we, mem_wstrb} !== 5'd0) begin bad++; $display("FAIL fetch_we_strb got=%b/%h want=0/0", mem_we, mem_wstrb); end
    total++; if ({if_resp_valid, d_resp_valid} !== 2'b00) begin bad++; $display("FAIL fetch_early_resp got=%b%b want=00", if_resp_valid, d_resp_valid); end
    @(negedge clk);
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    total++; if ({if_resp_valid, d_resp_valid} !== 2'b10) begin bad++; $display("FAIL fetch_resp_valid got=%b%b want=10", if_resp_valid, d_resp_valid); end
    total++; if (if_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fetch_rdata got=%h want=deadbeef", if_rdata); end
    @(negedge clk);
    mem_resp_valid = 0;
    #1;
    total++; if ({busy, if_resp_valid, if_rdata} !== 34'd0) begin bad++; $display("FAIL fetch_after got busy=%b rv=%b rdata=%h want=0", busy, if_resp_valid, if_rdata); end
  endtask

  task automatic test_store();
    @(negedge clk);
    d_req_valid = 1; d_we = 1; d_addr = 32'h100; d_wstrb = 4'b0011; d_wdata = 32'h1234_5678;
    #1;
    total++; if ({if_req_ready, d_req_ready} !== 2'b01) begin bad++; $display("FAIL store_ready got=%b%b want=01", if_req_ready, d_req_ready); end
    @(negedge clk);
    d_req_valid = 0; d_we = 0; d_addr = 32'hFFFF_FFFF; d_wstrb = 4'hF; d_wdata = 0;
    for (int i = 0; i < 4; i++) begin
      mem_req_ready = (i == 3);
      #1;
      total++; if ({mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata} !== {1'b1, 32'h100, 1'b1, 4'b0011, 32'h1234_5678})
        begin bad++; $display("FAIL store_req_cycle%0d got v=%b a=%h we=%b s=%h d=%h", i, mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata); end
      @(negedge clk);
    end
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0BAD_F00D;
    #1;
    total++; if ({if_resp_valid, d_resp_valid} !== 2'b01) begin bad++; $display("FAIL store_resp got=%b%b want=01", if_resp_valid, d_resp_valid); end
    @(negedge clk);
    mem_resp_valid = 0;
    #1;
    total++; if ({d_resp_valid, busy} !== 2'b00) begin bad++; $display("FAIL store_resp_once got rv=%b busy=%b want=00", d_resp_valid, busy); end
  endtask

  task automatic test_contention();
    @(negedge clk);
    rst_n = 0; idle_inputs();
    if_req_valid = 1; if_addr = 32'h40; d_req_valid = 1; d_addr = 32'h80; d_we = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      logic exp_d;
      exp_d = k[0];
      mem_resp_valid = 0;
      #1;
      total++; if ({if_req_ready, d_req_ready} !== {~exp_d, exp_d}) begin bad++; $display("FAIL contention_grant%0d got=%b%b want=%b%b", k, if_req_ready, d_req_ready, ~exp_d, exp_d); end
      @(negedge clk);
      mem_req_ready = 1;
      #1;
      total++; if (mem_addr !== (exp_d ? 32'h80 : 32'h40)) begin bad++; $display("FAIL contention_addr%0d got=%h want=%h", k, mem_addr, exp_d ? 32'h80 : 32'h40); end
      @(negedge clk);
      mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'hC0DE_0000 + k;
      #1;
      total++; if ({if_resp_valid, d_resp_valid} !== {~exp_d, exp_d}) begin bad++; $display("FAIL contention_resp%0d got=%b%b want=%b%b", k, if_resp_valid, d_resp_valid, ~exp_d, exp_d); end
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_load_strb();
    @(negedge clk);
    d_req_valid = 1; d_we = 0; d_wstrb = 4'b1111; d_addr = 32'h204; d_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    d_req_valid = 0;
    #1;
    total++; if ({mem_we, mem_wstrb} !== 5'd0) begin bad++; $display("FAIL load_we_strb got=%b/%b want=0/0000", mem_we, mem_wstrb); end
    total++; if (mem_addr !== 32'h204) begin bad++; $display("FAIL load_addr got=%h want=00000204", mem_addr); end
    mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'hA5A5_0001;
    #1;
    total++; if ({d_resp_valid, d_rdata} !== {1'b1, 32'hA5A5_0001}) begin bad++; $display("FAIL load_resp got=%b/%h want=1/a5a50001", d_resp_valid, d_rdata); end
    @(negedge clk);
    mem_resp_valid = 0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    if_req_valid = 1; if_addr = 32'h300;
    @(negedge clk);
    mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    #1;
    total++; if ({busy, mem_req_valid} !== 2'b10) begin bad++; $display("FAIL midrst_in_resp got busy=%b mrv=%b want=10", busy, mem_req_valid); end
    mem_resp_valid = 1; mem_rdata = 32'h7777_7777; d_req_valid = 1; rst_n = 0;
    #1;
    total++; if ({if_resp_valid, d_resp_valid} !== 2'b00) begin bad++; $display("FAIL midrst_resp got=%b%b want=00", if_resp_valid, d_resp_valid); end
    total++; if ({busy, mem_req_valid, if_req_ready, d_req_ready} !== 4'd0) begin bad++; $display("FAIL midrst_ctrl got busy=%b mrv=%b rdy=%b%b want=0", busy, mem_req_valid, if_req_ready, d_req_ready); end
    total++; if ({if_rdata, d_rdata, mem_addr} !== 96'd0) begin bad++; $display("FAIL midrst_data got=%h/%h/%h want=0", if_rdata, d_rdata, mem_addr); end
    @(negedge clk);
    mem_resp_valid = 0; rst_n = 1;
    #1;
    total++; if ({if_req_ready, d_req_ready} !== 2'b10) begin bad++; $display("FAIL midrst_first_tie got=%b%b want=10", if_req_ready, d_req_ready); end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_stray();
    @(negedge clk);
    mem_resp_valid = 1; mem_rdata = 32'h1111_2222;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if ({if_resp_valid, d_resp_valid, busy} !== 3'b000) begin bad++; $display("FAIL stray_idle%0d got rv=%b%b busy=%b want=000", i, if_resp_valid, d_resp_valid, busy); end
      @(negedge clk);
    end
    mem_resp_valid = 0; d_req_valid = 1; d_addr = 32'h400;
    @(negedge clk);
    d_req_valid = 0; mem_resp_valid = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if ({mem_req_valid, if_resp_valid, d_resp_valid} !== 3'b100) begin bad++; $display("FAIL stray_req%0d got mrv=%b rv=%b%b want=100", i, mem_req_valid, if_resp_valid, d_resp_valid); end
      @(negedge clk);
    end
    mem_resp_valid = 0; mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h3333_4444;
    #1;
    total++; if ({d_resp_valid, d_rdata} !== {1'b1, 32'h3333_4444}) begin bad++; $display("FAIL stray_final_resp got=%b/%h want=1/33334444", d_resp_valid, d_rdata); end
    @(negedge clk);
    mem_resp_valid = 0;
  endtask

  task automatic test_random();
    logic        pend[2], last_d, inflight, at_mem, e_d, e_we, g_d, any;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    do_reset();
    pend = '{0, 0}; last_d = 1; inflight = 0; at_mem = 0;
    e_d = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_wstrb = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (!pend[0] && $urandom_range(0, 1) == 1) begin pend[0] = 1; if_addr = $urandom; end
      if (!pend[1] && $urandom_range(0, 2) == 0) begin
        pend[1] = 1; d_addr = $urandom; d_we = 1'($urandom); d_wstrb = 4'($urandom); d_wdata = $urandom;
      end
      if_req_valid = pend[0]; d_req_valid = pend[1];
      mem_req_ready = 1'($urandom);
      mem_resp_valid = at_mem && ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      #1;
      any = !inflight && (pend[0] || pend[1]);
      g_d = (pend[0] && pend[1]) ? !last_d : pend[1];
      total++; if ({if_req_ready, d_req_ready} !== {any && !g_d, any && g_d}) begin bad++; $display("FAIL rnd_ready c=%0d got=%b%b want=%b%b", c, if_req_ready, d_req_ready, any && !g_d, any && g_d); end
      total++; if (busy !== inflight) begin bad++; $display("FAIL rnd_busy c=%0d got=%b want=%b", c, busy, inflight); end
      total++; if (mem_req_valid !== (inflight && !at_mem)) begin bad++; $display("FAIL rnd_mem_req_valid c=%0d got=%b want=%b", c, mem_req_valid, inflight && !at_mem); end
      if (inflight && !at_mem) begin
        total++; if ({mem_addr, mem_we, mem_wstrb, mem_wdata} !== {e_addr, e_we, e_wstrb, e_wdata})
          begin bad++; $display("FAIL rnd_fields c=%0d got=%h/%b/%h/%h want=%h/%b/%h/%h", c, mem_addr, mem_we, mem_wstrb, mem_wdata, e_addr, e_we, e_wstrb, e_wdata); end
      end
      if (at_mem && mem_resp_valid) begin
        total++; if ({if_resp_valid, d_resp_valid} !== {!e_d, e_d}) begin bad++; $display("FAIL rnd_resp_route c=%0d got=%b%b want=%b%b", c, if_resp_valid, d_resp_valid, !e_d, e_d); end
        total++; if ((e_d ? d_rdata : if_rdata) !== mem_rdata) begin bad++; $display("FAIL rnd_rdata c=%0d got=%h want=%h", c, e_d ? d_rdata : if_rdata, mem_rdata); end
      end else begin
        total++; if ({if_resp_valid, d_resp_valid, if_rdata, d_rdata} !== 66'd0) begin bad++; $display("FAIL rnd_no_resp c=%0d got rv=%b%b rdata=%h/%h want=0", c, if_resp_valid, d_resp_valid, if_rdata, d_rdata); end
      end
      if (any) begin
        inflight = 1; last_d = g_d; e_d = g_d; pend[g_d] = 0;
        e_addr  = g_d ? d_addr : {if_addr[31:2], 2'b00};
        e_we    = g_d && d_we;
        e_wstrb = (g_d && d_we) ? d_wstrb : 4'h0;
        e_wdata = g_d ? d_wdata : 32'h0;
      end else if (inflight && !at_mem && mem_req_ready) at_mem = 1;
      else if (at_mem && mem_resp_valid) begin inflight = 0; at_mem = 0; end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_store();
    test_contention();
    test_load_strb();
    test_reset_mid();
    test_stray();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
